voice_scheduler: RTL and testbench
==================================

// Module: voice_scheduler
// PURPOSE
//   Sequences the per-voice synthesis pipeline (read / compute / update phases)
//   feeding the wavetable and phase-accumulator datapath. Once per sample tick it
//   walks every voice index in order, emitting the voice index and pipeline phase.
//   It also owns a one-entry buffer for voice parameter updates (phase increment)
//   and releases each update to the voice RAM only in a safe slot (UPDATE or IDLE).
// PARAMETERS
//   NUM_VOICES   128  voices serviced per frame; must satisfy 1 <= NUM_VOICES <= 2**VOICE_W
//   VOICE_W      8    voice index width
//   PHASE_INC_W  16   phase-increment (delta phase) width
// PORTS
//   i_clk               in   1            system clock
//   i_reset             in   1            synchronous, active-high reset
//   i_sample_tick       in   1            one-cycle strobe at audio sample rate
//   i_upd_valid         in   1            update request valid
//   i_upd_voice         in   VOICE_W      voice to update
//   i_upd_delta         in   PHASE_INC_W  new phase increment
//   o_upd_ready         out  1            buffer empty, request accepted when valid&ready
//   o_voice_index       out  VOICE_W      voice currently in pipeline
//   o_pipeline_state    out  2            0=READ 1=COMPUTE 2=UPDATE 3=IDLE
//   o_ram_we            out  1            write strobe for voice parameter RAM
//   o_ram_addr          out  VOICE_W      RAM write address (buffered update voice)
//   o_ram_delta         out  PHASE_INC_W  RAM write data
//   o_frame_done        out  1            one-cycle pulse, all voices processed
//   o_overrun           out  1            sticky: tick arrived while frame busy
// BEHAVIOUR
//   Reset values: state IDLE (o_pipeline_state=3), o_voice_index=0, o_upd_ready=1,
//     o_ram_we=0, o_ram_addr=0, o_ram_delta=0, o_frame_done=0, o_overrun=0.
//   Reset mid-frame: abandon frame, discard buffered update, all outputs to reset values.
//   FSM: IDLE --tick--> READ(voice 0); READ->COMPUTE->UPDATE unconditionally;
//     UPDATE -> READ with voice+1 if voice < NUM_VOICES-1, else -> IDLE.
//   Timing: tick sampled at edge t -> READ/voice 0 in cycle t+1; frame = 3*NUM_VOICES
//     cycles; first IDLE cycle is t+1+3*NUM_VOICES with o_frame_done=1 that cycle only.
//   o_voice_index holds for all three phases of a voice; increments only on UPDATE->READ;
//     returns to 0 on entering IDLE; never exceeds NUM_VOICES-1.
//   Tick while state != IDLE: ignored (no restart), o_overrun set until reset.
//   Tick in same cycle as o_frame_done (first IDLE cycle): accepted normally.
//   Update buffer: captures voice/delta on i_upd_valid & o_upd_ready; o_upd_ready = !pending.
//     o_ram_we = pending & (state==UPDATE | state==IDLE); o_ram_addr/o_ram_delta driven
//     from buffer registers; pending clears at the edge ending the o_ram_we cycle,
//     so o_upd_ready returns high the following cycle. At most one write per slot.
//   Updates never write during READ or COMPUTE; target voice is independent of
//     o_voice_index (write to current voice in UPDATE is legal and intended).
//   i_upd_voice >= NUM_VOICES: accepted but dropped (no o_ram_we), ready returns next cycle.
//   All outputs derived from registers only; no combinational input->output path.
// STRUCTURE
//   synth_pkg: pipeline state encodings (PS_READ=0, PS_COMPUTE=1, PS_UPDATE=2,
//     PS_IDLE=3), default VOICE_W / PHASE_INC_W, NUM_VOICES default.
//   Sub-module upd_slot: one-entry valid/ready holding register with pop input,
//     instantiated once; FSM, voice counter and overrun flag live in top level.
// TESTING
//   1 Reset then tick at cycle 10 (NUM_VOICES=4) -> states 0,1,2 x4 from cycle 11,
//     voice 0..3, IDLE at cycle 23 with o_frame_done=1 for exactly one cycle.
//   2 Tick at cycle 15 during frame of test 1 -> ignored, frame ends cycle 23,
//     o_overrun=1 from cycle 16 and stays 1 until i_reset.
//   3 Update voice=2 delta=0x1234 presented while in READ -> o_upd_ready drops next
//     cycle, o_ram_we=1 addr=2 data=0x1234 only in next UPDATE cycle, ready high after.
//   4 Update in IDLE -> o_ram_we one cycle after capture; back-to-back valid -> second
//     request accepted only after ready returns, both written, none lost or duplicated.
//   5 i_reset asserted mid-frame with update pending -> next cycle IDLE, voice 0,
//     ready=1, o_ram_we never asserted for the pending update.
//   6 Update with voice=200 (NUM_VOICES=128) -> accepted, no o_ram_we, ready restored;
//     tick coincident with o_frame_done -> new frame starts next cycle.

Source files
------------

// File: rtl/synth_pkg.sv
// ---------------------------------------------------------------------------
// synth_pkg
//   Shared definitions for the voice synthesis pipeline.
//
//   Contents:
//     pipe_state_t          pipeline phase encoding reported on o_pipeline_state
//                           (PS_READ=0, PS_COMPUTE=1, PS_UPDATE=2, PS_IDLE=3)
//     DEFAULT_NUM_VOICES    voices serviced per frame
//     DEFAULT_VOICE_W       voice index width
//     DEFAULT_PHASE_INC_W   phase-increment width
// ---------------------------------------------------------------------------
package synth_pkg;

    typedef enum logic [1:0] {
        PS_READ    = 2'd0,
        PS_COMPUTE = 2'd1,
        PS_UPDATE  = 2'd2,
        PS_IDLE    = 2'd3
    } pipe_state_t;

    localparam int DEFAULT_NUM_VOICES  = 128;
    localparam int DEFAULT_VOICE_W     = 8;
    localparam int DEFAULT_PHASE_INC_W = 16;

endpackage

// File: rtl/upd_slot.sv
// ---------------------------------------------------------------------------
// upd_slot
//   One-entry holding register for voice parameter updates. A request is
//   captured when push_valid meets o_ready; the entry stays pending until
//   the owner pops it, after which the slot can accept again the next cycle.
//
//   Ports:
//     i_clk         in   1             system clock
//     i_reset       in   1             synchronous, active-high reset
//     i_push_valid  in   1             request valid
//     i_push_voice  in   VOICE_W       request voice index
//     i_push_delta  in   PHASE_INC_W   request phase increment
//     o_ready       out  1             slot empty
//     i_pop         in   1             release the pending entry at this edge
//     o_pending     out  1             slot holds an entry
//     o_voice       out  VOICE_W       buffered voice index
//     o_delta       out  PHASE_INC_W   buffered phase increment
// ---------------------------------------------------------------------------
module upd_slot #(
    parameter int VOICE_W     = 8,
    parameter int PHASE_INC_W = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_push_valid,
    input  logic [VOICE_W-1:0]     i_push_voice,
    input  logic [PHASE_INC_W-1:0] i_push_delta,
    output logic                   o_ready,
    input  logic                   i_pop,
    output logic                   o_pending,
    output logic [VOICE_W-1:0]     o_voice,
    output logic [PHASE_INC_W-1:0] o_delta
);

    logic                   pending;
    logic [VOICE_W-1:0]     voice_q;
    logic [PHASE_INC_W-1:0] delta_q;

    // Pop takes priority over push: while an entry is pending the slot is
    // not ready, so a push can only ever land in an empty slot. Clearing on
    // pop means ready is seen high one cycle after the releasing cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pending <= 1'b0;
            voice_q <= '0;
            delta_q <= '0;
        end else if (pending) begin
            if (i_pop) begin
                pending <= 1'b0;
            end
        end else if (i_push_valid) begin
            pending <= 1'b1;
            voice_q <= i_push_voice;
            delta_q <= i_push_delta;
        end
    end

    // Ready is purely a function of the pending register, so there is no
    // combinational path from the request inputs to the handshake output.
    assign o_ready   = !pending;
    assign o_pending = pending;
    assign o_voice   = voice_q;
    assign o_delta   = delta_q;

endmodule

// File: rtl/voice_scheduler.sv
// ---------------------------------------------------------------------------
// voice_scheduler
//   Sequences the per-voice synthesis pipeline. On each sample tick it walks
//   voices 0..NUM_VOICES-1, spending one cycle each in READ, COMPUTE and
//   UPDATE, then parks in IDLE. Parameter updates are buffered in a single
//   slot and written to the voice RAM only during UPDATE or IDLE cycles.
//
//   Ports:
//     i_clk             in   1             system clock
//     i_reset           in   1             synchronous, active-high reset
//     i_sample_tick     in   1             one-cycle strobe at sample rate
//     i_upd_valid       in   1             update request valid
//     i_upd_voice       in   VOICE_W       voice to update
//     i_upd_delta       in   PHASE_INC_W   new phase increment
//     o_upd_ready       out  1             update buffer empty
//     o_voice_index     out  VOICE_W       voice currently in the pipeline
//     o_pipeline_state  out  2             0=READ 1=COMPUTE 2=UPDATE 3=IDLE
//     o_ram_we          out  1             voice parameter RAM write strobe
//     o_ram_addr        out  VOICE_W       RAM write address
//     o_ram_delta       out  PHASE_INC_W   RAM write data
//     o_frame_done      out  1             one-cycle pulse on first IDLE cycle
//     o_overrun         out  1             sticky: tick arrived mid-frame
// ---------------------------------------------------------------------------
module voice_scheduler
    import synth_pkg::*;
#(
    parameter int NUM_VOICES  = DEFAULT_NUM_VOICES,
    parameter int VOICE_W     = DEFAULT_VOICE_W,
    parameter int PHASE_INC_W = DEFAULT_PHASE_INC_W
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_sample_tick,
    input  logic                   i_upd_valid,
    input  logic [VOICE_W-1:0]     i_upd_voice,
    input  logic [PHASE_INC_W-1:0] i_upd_delta,
    output logic                   o_upd_ready,
    output logic [VOICE_W-1:0]     o_voice_index,
    output logic [1:0]             o_pipeline_state,
    output logic                   o_ram_we,
    output logic [VOICE_W-1:0]     o_ram_addr,
    output logic [PHASE_INC_W-1:0] o_ram_delta,
    output logic                   o_frame_done,
    output logic                   o_overrun
);

    localparam logic [VOICE_W-1:0] LAST_VOICE  = VOICE_W'(NUM_VOICES - 1);
    localparam logic [VOICE_W:0]   VOICE_LIMIT = (VOICE_W + 1)'(NUM_VOICES);

    pipe_state_t            state;
    pipe_state_t            state_next;
    logic [VOICE_W-1:0]     voice_index;
    logic [VOICE_W-1:0]     voice_next;
    logic                   frame_done;
    logic                   frame_done_next;
    logic                   overrun;

    logic                   slot_ready;
    logic                   slot_pending;
    logic                   slot_pop;
    logic [VOICE_W-1:0]     slot_voice;
    logic [PHASE_INC_W-1:0] slot_delta;
    logic                   slot_in_range;
    logic                   safe_slot;

    // Pipeline state, voice counter and the frame-done pulse are all held in
    // registers so every scheduler output is glitch-free and input-isolated.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= PS_IDLE;
            voice_index <= '0;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_next;
            voice_index <= voice_next;
            frame_done  <= frame_done_next;
        end
    end

    // Next-state logic. A tick is only honoured in IDLE, which includes the
    // cycle carrying the frame-done pulse, so back-to-back frames need no gap.
    // The counter advances only on UPDATE->READ and wraps to zero on the way
    // into IDLE, so it never exceeds the last voice.
    always_comb begin
        state_next      = state;
        voice_next      = voice_index;
        frame_done_next = 1'b0;
        unique case (state)
            PS_IDLE: begin
                if (i_sample_tick) begin
                    state_next = PS_READ;
                    voice_next = '0;
                end
            end
            PS_READ: begin
                state_next = PS_COMPUTE;
            end
            PS_COMPUTE: begin
                state_next = PS_UPDATE;
            end
            PS_UPDATE: begin
                if (voice_index < LAST_VOICE) begin
                    state_next = PS_READ;
                    voice_next = voice_index + 1'b1;
                end else begin
                    state_next      = PS_IDLE;
                    voice_next      = '0;
                    frame_done_next = 1'b1;
                end
            end
            default: begin
                state_next = PS_IDLE;
                voice_next = '0;
            end
        endcase
    end

    // A tick landing while a frame is still running means the pipeline is
    // too slow for the sample rate; remember it until the next reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            overrun <= 1'b0;
        end else if (i_sample_tick && (state != PS_IDLE)) begin
            overrun <= 1'b1;
        end
    end

    // Only UPDATE and IDLE cycles leave the voice RAM free for writes. An
    // entry addressing a non-existent voice is released immediately without
    // a write so the requester is never stalled by a bad index.
    assign safe_slot     = (state == PS_UPDATE) || (state == PS_IDLE);
    assign slot_in_range = ({1'b0, slot_voice} < VOICE_LIMIT);
    assign slot_pop      = slot_pending && (safe_slot || !slot_in_range);

    upd_slot #(
        .VOICE_W     (VOICE_W),
        .PHASE_INC_W (PHASE_INC_W)
    ) u_upd_slot (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_push_valid (i_upd_valid),
        .i_push_voice (i_upd_voice),
        .i_push_delta (i_upd_delta),
        .o_ready      (slot_ready),
        .i_pop        (slot_pop),
        .o_pending    (slot_pending),
        .o_voice      (slot_voice),
        .o_delta      (slot_delta)
    );

    assign o_upd_ready      = slot_ready;
    assign o_voice_index    = voice_index;
    assign o_pipeline_state = state;
    assign o_ram_we         = slot_pending && slot_in_range && safe_slot;
    assign o_ram_addr       = slot_voice;
    assign o_ram_delta      = slot_delta;
    assign o_frame_done     = frame_done;
    assign o_overrun        = overrun;

endmodule

// File: tb/tb_voice_scheduler.sv
// ---------------------------------------------------------------------------
// tb_voice_scheduler
//   Directed bench for voice_scheduler with a four-voice frame. Each task
//   drives one scenario and compares outputs against hand-derived values.
// ---------------------------------------------------------------------------
module tb_voice_scheduler;

    localparam int NV = 4;
    localparam int VW = 8;
    localparam int PW = 16;

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic          i_sample_tick;
    logic          i_upd_valid;
    logic [VW-1:0] i_upd_voice;
    logic [PW-1:0] i_upd_delta;
    logic          o_upd_ready;
    logic [VW-1:0] o_voice_index;
    logic [1:0]    o_pipeline_state;
    logic          o_ram_we;
    logic [VW-1:0] o_ram_addr;
    logic [PW-1:0] o_ram_delta;
    logic          o_frame_done;
    logic          o_overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_count = 0;

    voice_scheduler #(
        .NUM_VOICES  (NV),
        .VOICE_W     (VW),
        .PHASE_INC_W (PW)
    ) dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_sample_tick    (i_sample_tick),
        .i_upd_valid      (i_upd_valid),
        .i_upd_voice      (i_upd_voice),
        .i_upd_delta      (i_upd_delta),
        .o_upd_ready      (o_upd_ready),
        .o_voice_index    (o_voice_index),
        .o_pipeline_state (o_pipeline_state),
        .o_ram_we         (o_ram_we),
        .o_ram_addr       (o_ram_addr),
        .o_ram_delta      (o_ram_delta),
        .o_frame_done     (o_frame_done),
        .o_overrun        (o_overrun)
    );

    // Free-running 10-unit clock.
    always #5 i_clk = ~i_clk;

    // Count RAM write cycles, sampled mid-cycle away from the active edge.
    always @(negedge i_clk) begin
        if (o_ram_we === 1'b1) begin
            wr_count++;
        end
    end

    // Advance one cycle and settle just past the edge.
    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_reset       = 1'b1;
        i_sample_tick = 1'b0;
        i_upd_valid   = 1'b0;
        i_upd_voice   = '0;
        i_upd_delta   = '0;
        cyc();
        cyc();
        i_reset = 1'b0;
        n_checks++;
        if (o_pipeline_state !== 2'd3 || o_voice_index !== 8'd0 || o_upd_ready !== 1'b1 ||
            o_ram_we !== 1'b0 || o_ram_addr !== 8'd0 || o_ram_delta !== 16'd0 ||
            o_frame_done !== 1'b0 || o_overrun !== 1'b0) begin
            $display("[TB] FAIL reset_values got st=%0d v=%0d rdy=%b we=%b a=%0d d=%h fd=%b ov=%b want st=3 v=0 rdy=1 we=0 a=0 d=0 fd=0 ov=0",
                     o_pipeline_state, o_voice_index, o_upd_ready, o_ram_we, o_ram_addr,
                     o_ram_delta, o_frame_done, o_overrun);
            n_fail++;
        end
        cyc();
        cyc();
    endtask

    task automatic test_frame();
        i_sample_tick = 1'b1;
        cyc();
        i_sample_tick = 1'b0;
        for (int k = 0; k < 3 * NV; k++) begin
            n_checks++;
            if (o_pipeline_state !== 2'(k % 3) || o_voice_index !== 8'(k / 3) ||
                o_frame_done !== 1'b0 || o_overrun !== 1'b0) begin
                $display("[TB] FAIL frame_seq k=%0d got st=%0d v=%0d fd=%b ov=%b want st=%0d v=%0d fd=0 ov=0",
                         k, o_pipeline_state, o_voice_index, o_frame_done, o_overrun, k % 3, k / 3);
                n_fail++;
            end
            cyc();
        end
        n_checks++;
        if (o_pipeline_state !== 2'd3 || o_voice_index !== 8'd0 || o_frame_done !== 1'b1) begin
            $display("[TB] FAIL frame_end got st=%0d v=%0d fd=%b want st=3 v=0 fd=1",
                     o_pipeline_state, o_voice_index, o_frame_done);
            n_fail++;
        end
        cyc();
        n_checks++;
        if (o_pipeline_state !== 2'd3 || o_frame_done !== 1'b0) begin
            $display("[TB] FAIL frame_done_pulse got st=%0d fd=%b want st=3 fd=0",
                     o_pipeline_state, o_frame_done);
            n_fail++;
        end
    endtask

    task automatic test_overrun();
        i_sample_tick = 1'b1;
        cyc();
        i_sample_tick = 1'b0;
        for (int k = 0; k < 3 * NV; k++) begin
            n_checks++;
            if (o_pipeline_state !== 2'(k % 3) || o_voice_index !== 8'(k / 3) ||
                o_overrun !== (k >= 5)) begin
                $display("[TB] FAIL overrun_seq k=%0d got st=%0d v=%0d ov=%b want st=%0d v=%0d ov=%b",
                         k, o_pipeline_state, o_voice_index, o_overrun, k % 3, k / 3, (k >= 5));
                n_fail++;
            end
            i_sample_tick = (k == 4);
            cyc();
            i_sample_tick = 1'b0;
        end
        n_checks++;
        if (o_pipeline_state !== 2'd3 || o_frame_done !== 1'b1 || o_overrun !== 1'b1) begin
            $display("[TB] FAIL overrun_end got st=%0d fd=%b ov=%b want st=3 fd=1 ov=1",
                     o_pipeline_state, o_frame_done, o_overrun);
            n_fail++;
        end
        cyc();
        cyc();
        n_checks++;
        if (o_overrun !== 1'b1 || o_pipeline_state !== 2'd3) begin
            $display("[TB] FAIL overrun_sticky got ov=%b st=%0d want ov=1 st=3", o_overrun, o_pipeline_state);
            n_fail++;
        end
    endtask

    task automatic test_update_in_frame();
        int w0;
        i_sample_tick = 1'b1;
        cyc();
        i_sample_tick = 1'b0;
        w0 = wr_count;
        i_upd_valid = 1'b1;
        i_upd_voice = 8'd2;
        i_upd_delta = 16'h1234;
        n_checks++;
        if (o_pipeline_state !== 2'd0 || o_upd_ready !== 1'b1) begin
            $display("[TB] FAIL upd_pre got st=%0d rdy=%b want st=0 rdy=1", o_pipeline_state, o_upd_ready);
            n_fail++;
        end
        cyc();
        i_upd_valid = 1'b0;
        n_checks++;
        if (o_pipeline_state !== 2'd1 || o_upd_ready !== 1'b0 || o_ram_we !== 1'b0) begin
            $display("[TB] FAIL upd_compute got st=%0d rdy=%b we=%b want st=1 rdy=0 we=0",
                     o_pipeline_state, o_upd_ready, o_ram_we);
            n_fail++;
        end
        cyc();
        n_checks++;
        if (o_pipeline_state !== 2'd2 || o_ram_we !== 1'b1 || o_ram_addr !== 8'd2 ||
            o_ram_delta !== 16'h1234 || o_upd_ready !== 1'b0) begin
            $display("[TB] FAIL upd_write got st=%0d we=%b a=%0d d=%h rdy=%b want st=2 we=1 a=2 d=1234 rdy=0",
                     o_pipeline_state, o_ram_we, o_ram_addr, o_ram_delta, o_upd_ready);
            n_fail++;
        end
        cyc();
        n_checks++;
        if (o_pipeline_state !== 2'd0 || o_ram_we !== 1'b0 || o_upd_ready !== 1'b1) begin
            $display("[TB] FAIL upd_after got st=%0d we=%b rdy=%b want st=0 we=0 rdy=1",
                     o_pipeline_state, o_ram_we, o_upd_ready);
            n_fail++;
        end
        repeat (3 * NV) cyc();
        n_checks++;
        if (wr_count - w0 !== 1 || o_pipeline_state !== 2'd3) begin
            $display("[TB] FAIL upd_write_count got writes=%0d st=%0d want writes=1 st=3",
                     wr_count - w0, o_pipeline_state);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        int w0;
        w0 = wr_count;
        i_upd_valid = 1'b1;
        i_upd_voice = 8'd1;
        i_upd_delta = 16'hAAAA;
        cyc();
        i_upd_voice = 8'd3;
        i_upd_delta = 16'h5555;
        n_checks++;
        if (o_ram_we !== 1'b1 || o_ram_addr !== 8'd1 || o_ram_delta !== 16'hAAAA || o_upd_ready !== 1'b0) begin
            $display("[TB] FAIL b2b_first got we=%b a=%0d d=%h rdy=%b want we=1 a=1 d=aaaa rdy=0",
                     o_ram_we, o_ram_addr, o_ram_delta, o_upd_ready);
            n_fail++;
        end
        cyc();
        n_checks++;
        if (o_ram_we !== 1'b0 || o_upd_ready !== 1'b1) begin
            $display("[TB] FAIL b2b_gap got we=%b rdy=%b want we=0 rdy=1", o_ram_we, o_upd_ready);
            n_fail++;
        end
        cyc();
        i_upd_valid = 1'b0;
        n_checks++;
        if (o_ram_we !== 1'b1 || o_ram_addr !== 8'd3 || o_ram_delta !== 16'h5555 || o_upd_ready !== 1'b0) begin
            $display("[TB] FAIL b2b_second got we=%b a=%0d d=%h rdy=%b want we=1 a=3 d=5555 rdy=0",
                     o_ram_we, o_ram_addr, o_ram_delta, o_upd_ready);
            n_fail++;
        end
        cyc();
        cyc();
        n_checks++;
        if (wr_count - w0 !== 2 || o_upd_ready !== 1'b1 || o_ram_we !== 1'b0) begin
            $display("[TB] FAIL b2b_count got writes=%0d rdy=%b we=%b want writes=2 rdy=1 we=0",
                     wr_count - w0, o_upd_ready, o_ram_we);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid_frame();
        int w0;
        i_sample_tick = 1'b1;
        cyc();
        i_sample_tick = 1'b0;
        repeat (3) cyc();
        w0 = wr_count;
        i_upd_valid = 1'b1;
        i_upd_voice = 8'd1;
        i_upd_delta = 16'hBEEF;
        cyc();
        i_upd_valid = 1'b0;
        i_reset     = 1'b1;
        n_checks++;
        if (o_pipeline_state !== 2'd1 || o_voice_index !== 8'd1 || o_upd_ready !== 1'b0) begin
            $display("[TB] FAIL rst_mid_pre got st=%0d v=%0d rdy=%b want st=1 v=1 rdy=0",
                     o_pipeline_state, o_voice_index, o_upd_ready);
            n_fail++;
        end
        cyc();
        i_reset = 1'b0;
        n_checks++;
        if (o_pipeline_state !== 2'd3 || o_voice_index !== 8'd0 || o_upd_ready !== 1'b1 ||
            o_ram_we !== 1'b0 || o_overrun !== 1'b0 || o_frame_done !== 1'b0) begin
            $display("[TB] FAIL rst_mid_post got st=%0d v=%0d rdy=%b we=%b ov=%b fd=%b want st=3 v=0 rdy=1 we=0 ov=0 fd=0",
                     o_pipeline_state, o_voice_index, o_upd_ready, o_ram_we, o_overrun, o_frame_done);
            n_fail++;
        end
        repeat (4) cyc();
        n_checks++;
        if (wr_count !== w0) begin
            $display("[TB] FAIL rst_mid_no_write got writes=%0d want 0", wr_count - w0);
            n_fail++;
        end
    endtask

    task automatic test_bad_voice();
        logic [VW-1:0] bad [2];
        int w0;
        bad[0] = 8'd200;
        bad[1] = 8'(NV);
        w0 = wr_count;
        for (int i = 0; i < 2; i++) begin
            i_upd_valid = 1'b1;
            i_upd_voice = bad[i];
            i_upd_delta = 16'hC0DE;
            cyc();
            i_upd_valid = 1'b0;
            n_checks++;
            if (o_upd_ready !== 1'b0 || o_ram_we !== 1'b0) begin
                $display("[TB] FAIL bad_voice_capture v=%0d got rdy=%b we=%b want rdy=0 we=0",
                         bad[i], o_upd_ready, o_ram_we);
                n_fail++;
            end
            cyc();
            n_checks++;
            if (o_upd_ready !== 1'b1 || o_ram_we !== 1'b0) begin
                $display("[TB] FAIL bad_voice_release v=%0d got rdy=%b we=%b want rdy=1 we=0",
                         bad[i], o_upd_ready, o_ram_we);
                n_fail++;
            end
        end
        n_checks++;
        if (wr_count !== w0) begin
            $display("[TB] FAIL bad_voice_writes got %0d want 0", wr_count - w0);
            n_fail++;
        end
    endtask

    task automatic test_tick_on_frame_done();
        i_sample_tick = 1'b1;
        cyc();
        i_sample_tick = 1'b0;
        repeat (3 * NV) cyc();
        n_checks++;
        if (o_frame_done !== 1'b1 || o_pipeline_state !== 2'd3) begin
            $display("[TB] FAIL tick_fd_pre got fd=%b st=%0d want fd=1 st=3", o_frame_done, o_pipeline_state);
            n_fail++;
        end
        i_sample_tick = 1'b1;
        cyc();
        i_sample_tick = 1'b0;
        n_checks++;
        if (o_pipeline_state !== 2'd0 || o_voice_index !== 8'd0 || o_frame_done !== 1'b0 || o_overrun !== 1'b0) begin
            $display("[TB] FAIL tick_fd_restart got st=%0d v=%0d fd=%b ov=%b want st=0 v=0 fd=0 ov=0",
                     o_pipeline_state, o_voice_index, o_frame_done, o_overrun);
            n_fail++;
        end
        repeat (3 * NV) cyc();
        n_checks++;
        if (o_frame_done !== 1'b1 || o_pipeline_state !== 2'd3) begin
            $display("[TB] FAIL tick_fd_second_end got fd=%b st=%0d want fd=1 st=3", o_frame_done, o_pipeline_state);
            n_fail++;
        end
        cyc();
    endtask

    initial begin
        test_reset();
        test_frame();
        test_overrun();
        test_update_in_frame();
        test_back_to_back();
        test_reset_mid_frame();
        test_bad_voice();
        test_tick_on_frame_done();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
